mem_arbiter: RTL and testbench

Two-port memory arbiter sitting directly downstream of the instruction cache and data cache, merging their line-fill and write-through traffic onto the single main-memory port. Each cache port mirrors the cache's memory-side interface: request, write-data and response channels. The arbiter grants one transaction at a time, holds the grant until that transaction completes, and routes read-response beats back to the owner only.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter merging I-cache (port 0) and D-cache (port 1) traffic onto one memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int BEATS         = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ic_mem_req_valid,
    output logic                       ic_mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                       ic_mem_req_rw,
    input  logic                       ic_mem_req_data_valid,
    output logic                       ic_mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                       ic_mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                       dc_mem_req_valid,
    output logic                       dc_mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                       dc_mem_req_rw,
    input  logic                       dc_mem_req_data_valid,
    output logic                       dc_mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                       dc_mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RRESP} state_t;

    state_t             state, state_n;
    logic               owner, owner_n;
    logic               last_grant, last_grant_n;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;

    logic                       tie_grant, grant;
    logic                       own_valid, own_rw, own_dvalid;
    logic [MEM_ADDR_BITS-1:0]   own_addr;
    logic [MEM_DATA_BITS-1:0]   own_bits;
    logic [MEM_DATA_BITS/8-1:0] own_mask;
    logic                       own_ready, own_dready, own_resp;
    logic [MEM_DATA_BITS-1:0]   resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            beat_cnt   <= beat_cnt_n;
        end
    end

`ifdef MEM_ARB_RR_EN
    assign tie_grant = ~last_grant;
`else
    assign tie_grant = 1'b1;
`endif

    always_comb begin
        state_n            = state;
        owner_n            = owner;
        last_grant_n       = last_grant;
        beat_cnt_n         = beat_cnt;
        grant              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        own_ready          = 1'b0;
        own_dready         = 1'b0;
        own_resp           = 1'b0;
        resp_data          = '0;

        own_valid  = owner ? dc_mem_req_valid      : ic_mem_req_valid;
        own_rw     = owner ? dc_mem_req_rw         : ic_mem_req_rw;
        own_addr   = owner ? dc_mem_req_addr       : ic_mem_req_addr;
        own_dvalid = owner ? dc_mem_req_data_valid : ic_mem_req_data_valid;
        own_bits   = owner ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
        own_mask   = owner ? dc_mem_req_data_mask  : ic_mem_req_data_mask;

        case (state)
            IDLE: begin
                if (ic_mem_req_valid || dc_mem_req_valid) begin
                    grant        = (ic_mem_req_valid && dc_mem_req_valid) ? tie_grant : dc_mem_req_valid;
                    owner_n      = grant;
                    last_grant_n = grant;
                    beat_cnt_n   = '0;
                    state_n      = REQ;
                end
            end
            REQ: begin
                mem_req_valid = own_valid;
                mem_req_addr  = own_addr;
                mem_req_rw    = own_rw;
                own_ready     = mem_req_ready;
                // An owner that withdraws its request forfeits the grant.
                if (!own_valid)
                    state_n = IDLE;
                else if (mem_req_ready)
                    state_n = own_rw ? WDATA : RRESP;
            end
            WDATA: begin
                mem_req_data_valid = own_dvalid;
                mem_req_data_bits  = own_bits;
                mem_req_data_mask  = own_mask;
                own_dready         = mem_req_data_ready;
                if (own_dvalid && mem_req_data_ready)
                    state_n = IDLE;
            end
            RRESP: begin
                own_resp  = mem_resp_valid;
                resp_data = mem_resp_data;
                if (mem_resp_valid) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                    if (beat_cnt == CNT_W'(BEATS - 1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        ic_mem_req_ready      = own_ready  & ~owner;
        dc_mem_req_ready      = own_ready  &  owner;
        ic_mem_req_data_ready = own_dready & ~owner;
        dc_mem_req_data_ready = own_dready &  owner;
        ic_mem_resp_valid     = own_resp   & ~owner;
        dc_mem_resp_valid     = own_resp   &  owner;
        ic_mem_resp_data      = resp_data;
        dc_mem_resp_data      = resp_data;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of grants, handshakes and beat routing.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic reset;

    logic          ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
    logic [AW-1:0] ic_mem_req_addr;
    logic          ic_mem_req_data_valid, ic_mem_req_data_ready;
    logic [DW-1:0] ic_mem_req_data_bits;
    logic [MW-1:0] ic_mem_req_data_mask;
    logic          ic_mem_resp_valid;
    logic [DW-1:0] ic_mem_resp_data;

    logic          dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
    logic [AW-1:0] dc_mem_req_addr;
    logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
    logic [DW-1:0] dc_mem_req_data_bits;
    logic [MW-1:0] dc_mem_req_data_mask;
    logic          dc_mem_resp_valid;
    logic [DW-1:0] dc_mem_resp_data;

    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    mem_arbiter #(
        .MEM_ADDR_BITS(AW),
        .MEM_DATA_BITS(DW),
        .BEATS(NB)
    ) dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
        .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
        .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
        .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
        .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
        .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
        .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
        .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
        .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Pending transaction per port: pend = request outstanding, dv = write data outstanding.
    logic          pend [2];
    logic          dv   [2];
    logic          p_rw [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic [MW-1:0] p_mask [2];
    logic [DW-1:0] beat_val [NB];
    int            model_last;
    int            checks   = 0;
    int            failures = 0;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {mem_req_valid, mem_req_data_valid, dc_mem_req_ready, ic_mem_req_ready,
                dc_mem_req_data_ready, ic_mem_req_data_ready, dc_mem_resp_valid, ic_mem_resp_valid};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply();
        ic_mem_req_valid      = pend[0];
        ic_mem_req_addr       = p_addr[0];
        ic_mem_req_rw         = p_rw[0];
        ic_mem_req_data_valid = dv[0];
        ic_mem_req_data_bits  = p_data[0];
        ic_mem_req_data_mask  = p_mask[0];
        dc_mem_req_valid      = pend[1];
        dc_mem_req_addr       = p_addr[1];
        dc_mem_req_rw         = p_rw[1];
        dc_mem_req_data_valid = dv[1];
        dc_mem_req_data_bits  = p_data[1];
        dc_mem_req_data_mask  = p_mask[1];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int p, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        pend[p] = 1'b1;
        dv[p]   = rw;
        p_rw[p] = rw;
        p_addr[p] = a;
        p_data[p] = d;
        p_mask[p] = m;
    endtask

    function automatic int pick();
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
            return 1 - model_last;
`else
            return 1;
`endif
        end
        return pend[1] ? 1 : 0;
    endfunction

    // One arbitration round: idle cycle, request phase, then write data or read beats.
    task automatic run_txn(input int unsigned rwait, input int unsigned dwait,
                           input int unsigned gapmax, input logic stray);
        int w;
        logic [1:0] oh;
        mem_resp_valid = stray;
        mem_resp_data  = rnd_data();
        apply();
        #4;
        chk("idle_ctl", ctl(), 8'h00);
        if (!pend[0] && !pend[1]) begin
            tick();
            mem_resp_valid = 1'b0;
            return;
        end
        w = pick();
        model_last = w;
        oh = (w == 1) ? 2'b10 : 2'b01;
        tick();
        mem_resp_valid = 1'b0;

        for (int unsigned i = 0; i <= rwait; i++) begin
            mem_req_ready = (i == rwait);
            apply();
            #4;
            chk("req_ctl", ctl(), {2'b10, (i == rwait) ? oh : 2'b00, 4'b0000});
            chk("req_addr", mem_req_addr, p_addr[w]);
            chk("req_rw", mem_req_rw, p_rw[w]);
            tick();
        end
        mem_req_ready = 1'b0;
        pend[w] = 1'b0;

        if (p_rw[w]) begin
            for (int unsigned i = 0; i <= dwait; i++) begin
                mem_req_data_ready = (i == dwait);
                apply();
                #4;
                chk("wdata_ctl", ctl(), {4'b0100, (i == dwait) ? oh : 2'b00, 2'b00});
                chk("wdata_bits", mem_req_data_bits, p_data[w]);
                chk("wdata_mask", mem_req_data_mask, p_mask[w]);
                tick();
            end
            mem_req_data_ready = 1'b0;
            dv[w] = 1'b0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                int unsigned gap;
                gap = $urandom_range(0, gapmax);
                for (int unsigned g = 0; g < gap; g++) begin
                    mem_resp_valid = 1'b0;
                    apply();
                    #4;
                    chk("rgap_ctl", ctl(), 8'h00);
                    tick();
                end
                mem_resp_valid = 1'b1;
                mem_resp_data  = beat_val[b];
                apply();
                #4;
                chk("beat_ctl", ctl(), {6'b000000, oh});
                chk(w == 0 ? "beat_data_own" : "beat_data_other", ic_mem_resp_data, beat_val[b]);
                chk(w == 1 ? "beat_data_own" : "beat_data_other", dc_mem_resp_data, beat_val[b]);
                tick();
            end
            mem_resp_valid = 1'b0;
        end
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; dv[p] = 1'b0; p_rw[p] = 1'b0;
            p_addr[p] = '0; p_data[p] = '0; p_mask[p] = '0;
        end
        model_last         = 0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b1;
        mem_resp_data      = rnd_data();
        reset              = 1'b1;
        apply();
        tick();
        tick();

        // Reset state, with a stray memory beat and idle port inputs present.
        #4;
        chk("rst_ctl", ctl(), 8'h00);
        chk("rst_addr", mem_req_addr, '0);
        chk("rst_bits", mem_req_data_bits, '0);
        chk("rst_mask", mem_req_data_mask, '0);
        chk("rst_resp_data", ic_mem_resp_data, '0);
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b0;

        // Single I-cache read with fixed beats.
        for (int b = 0; b < NB; b++) beat_val[b] = DW'(10 + b);
        new_req(0, 1'b0, 28'h0000123, '0, '0);
        run_txn(0, 0, 0, 1'b0);

        // D-cache write.
        new_req(1, 1'b1, 28'h00000F0, 128'hDEADBEEF, 16'h000F);
        run_txn(0, 1, 0, 1'b0);

        // Three ties with both ports held valid.
        for (int k = 0; k < 3; k++) begin
            if (!pend[0]) new_req(0, 1'b0, AW'(32'h100 + k), '0, '0);
            if (!pend[1]) new_req(1, 1'b0, AW'(32'h200 + k), '0, '0);
            for (int b = 0; b < NB; b++) beat_val[b] = rnd_data();
            run_txn(0, 0, 0, 1'b0);
        end

        // Memory backpressure for five cycles with the other port also waiting.
        if (!pend[0]) new_req(0, 1'b0, 28'h0000300, '0, '0);
        if (!pend[1]) new_req(1, 1'b1, 28'h0000301, rnd_data(), 16'hFFFF);
        run_txn(5, 0, 0, 1'b0);
        while (pend[0] || pend[1]) run_txn(0, 0, 0, 1'b0);

        // Stray response beat while idle, then normal traffic resumes.
        run_txn(0, 0, 0, 1'b1);

        // Reset in the middle of a read after the second beat.
        for (int b = 0; b < NB; b++) beat_val[b] = rnd_data();
        new_req(0, 1'b0, 28'h0000456, '0, '0);
        apply();
        #4;
        chk("mr_idle_ctl", ctl(), 8'h00);
        tick();
        mem_req_ready = 1'b1;
        apply();
        #4;
        chk("mr_req_ctl", ctl(), 8'b10_01_00_00);
        tick();
        mem_req_ready = 1'b0;
        pend[0] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = beat_val[b];
            apply();
            #4;
            chk("mr_beat_ctl", ctl(), 8'b00_00_00_01);
            chk("mr_beat_data", ic_mem_resp_data, beat_val[b]);
            tick();
        end
        reset = 1'b1;
        mem_resp_data = beat_val[2];
        #4;
        chk("mr_rst_ctl", ctl(), 8'h00);
        chk("mr_rst_addr", mem_req_addr, '0);
        chk("mr_rst_resp_data", ic_mem_resp_data, '0);
        tick();
        reset = 1'b0;
        model_last = 0;
        mem_resp_data = beat_val[3];
        #4;
        chk("mr_late_beat_ctl", ctl(), 8'h00);
        tick();
        mem_resp_valid = 1'b0;
        new_req(1, 1'b0, 28'h0000789, '0, '0);
        for (int b = 0; b < NB; b++) beat_val[b] = rnd_data();
        run_txn(0, 0, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 9) < 6)
                    new_req(p, 1'($urandom_range(0, 1)), AW'($urandom), rnd_data(), MW'($urandom));
            for (int b = 0; b < NB; b++) beat_val[b] = rnd_data();
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
